// File: rtl/sram_test_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_test_pkg : shared types and data-pattern helper for the march BIST
// Revision 1.0
// ------------------------------------------------------------------
package sram_test_pkg;

   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      PH_P0 = 2'd0,
      PH_P1 = 2'd1,
      PH_P2 = 2'd2
   } phase_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_ADVANCE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      PAT_ZERO    = 2'd0,
      PAT_CHECKER = 2'd1,
      PAT_ADDR    = 2'd2,
      PAT_ONES    = 2'd3
   } pattern_e;

   function automatic logic [7:0] pattern_data(input logic [7:0] addr_lo, input pattern_e sel);
      case (sel)
         PAT_ZERO:    return 8'h00;
         PAT_CHECKER: return 8'h55;
         PAT_ADDR:    return addr_lo;
         default:     return 8'hFF;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_march_tester_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_march_tester_if : command/response bus between the BIST and the SRAM controller
// Revision 1.0
// ------------------------------------------------------------------
interface sram_march_tester_if #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 8
) ();
   logic              mem_start;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              mem_busy;

   modport master (
      output mem_start, mem_rw, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready, mem_busy
   );

   modport slave (
      input  mem_start, mem_rw, mem_addr, mem_wdata,
      output mem_rdata, mem_ready, mem_busy
   );
endinterface
`default_nettype wire

// File: rtl/sram_op_issuer.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_op_issuer : registers one command onto the bus and waits for busy or a timeout
// Revision 1.0
// ------------------------------------------------------------------
module sram_op_issuer
   import sram_test_pkg::*;
#(
   parameter int ADDR_W  = 21,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              issue,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              op_done,
   output logic              op_timeout,
   sram_march_tester_if.master mem
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic             waiting;
   logic [CNT_W-1:0] wait_cnt;

   assign op_done    = waiting && mem.mem_busy;
   assign op_timeout = waiting && !mem.mem_busy && (wait_cnt == CNT_W'(TIMEOUT));

   // Address/rw/data only load on issue, so they stay put for the whole wait.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem.mem_start <= 1'b0;
         mem.mem_rw    <= 1'b1;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         waiting       <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         mem.mem_start <= issue;
         if (issue) begin
            mem.mem_rw    <= cmd_rw;
            mem.mem_addr  <= cmd_addr;
            mem.mem_wdata <= cmd_wdata;
         end
         if (mem.mem_start) begin
            waiting  <= 1'b1;
            wait_cnt <= '0;
         end else if (op_done || op_timeout) begin
            waiting <= 1'b0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_march_tester.sv
`default_nettype none
// ------------------------------------------------------------------
// sram_march_tester : three-element march BIST sequencer with read-back compare
// Revision 1.0
// ------------------------------------------------------------------
module sram_march_tester
   import sram_test_pkg::*;
#(
   parameter int ADDR_W  = 21,
   parameter int DATA_W  = 8,
   parameter int ERR_W   = 16,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              test_start,
   input  logic [1:0]        pattern_sel,
   input  logic [ADDR_W-1:0] last_addr,
   sram_march_tester_if.master mem,
   output logic              test_busy,
   output logic              test_done,
   output logic              test_pass,
   output logic              test_timeout,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [DATA_W-1:0] first_err_data
);
   state_e            state, next_state;
   phase_e            phase, nxt_phase, op_phase;
   logic [ADDR_W-1:0] cur_addr, nxt_addr, op_addr, last_r;
   logic              p1_write, nxt_p1w, op_p1w;
   pattern_e          sel_r, op_sel;
   logic              issue, load_first, last_op;
   logic              op_done, op_timeout;
   logic              cmd_rw;
   logic [DATA_W-1:0] cmd_pat, cmd_wdata, cur_pat, exp_data;
   logic              mismatch;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      issue      = 1'b0;
      load_first = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (test_start) begin
               next_state = ST_ISSUE;
               issue      = 1'b1;
               load_first = 1'b1;
            end
         end
         ST_ISSUE: next_state = ST_WAIT;
         ST_WAIT: begin
            if (op_timeout)   next_state = ST_DONE;
            else if (op_done) next_state = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            if (last_op) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_ISSUE;
               issue      = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Successor of the current op; P1 alternates read/write at each address.
   always_comb begin
      nxt_phase = phase;
      nxt_addr  = cur_addr;
      nxt_p1w   = 1'b0;
      last_op   = 1'b0;
      case (phase)
         PH_P0: begin
            if (cur_addr == last_r) begin
               nxt_phase = PH_P1;
               nxt_addr  = '0;
            end else begin
               nxt_addr = cur_addr + 1'b1;
            end
         end
         PH_P1: begin
            if (!p1_write)                nxt_p1w   = 1'b1;
            else if (cur_addr == last_r)  nxt_phase = PH_P2;
            else                          nxt_addr  = cur_addr + 1'b1;
         end
         default: begin
            if (cur_addr == '0) last_op  = 1'b1;
            else                nxt_addr = cur_addr - 1'b1;
         end
      endcase
   end

   assign op_phase  = load_first ? PH_P0 : nxt_phase;
   assign op_addr   = load_first ? '0 : nxt_addr;
   assign op_p1w    = load_first ? 1'b0 : nxt_p1w;
   assign op_sel    = load_first ? pattern_e'(pattern_sel) : sel_r;
   assign cmd_rw    = (op_phase == PH_P2) || ((op_phase == PH_P1) && !op_p1w);
   assign cmd_pat   = DATA_W'(pattern_data(8'(op_addr), op_sel));
   assign cmd_wdata = cmd_rw ? '0 : ((op_phase == PH_P0) ? cmd_pat : ~cmd_pat);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase    <= PH_P0;
         cur_addr <= '0;
         p1_write <= 1'b0;
         sel_r    <= PAT_ZERO;
         last_r   <= '0;
      end else if (issue) begin
         phase    <= op_phase;
         cur_addr <= op_addr;
         p1_write <= op_p1w;
         if (load_first) begin
            sel_r  <= op_sel;
            last_r <= last_addr;
         end
      end
   end

   sram_op_issuer #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) u_issuer (
      .clk        (clk),
      .reset_n    (reset_n),
      .issue      (issue),
      .cmd_rw     (cmd_rw),
      .cmd_addr   (op_addr),
      .cmd_wdata  (cmd_wdata),
      .op_done    (op_done),
      .op_timeout (op_timeout),
      .mem        (mem)
   );

   // P1 reads expect the true pattern, P2 reads its complement.
   assign cur_pat  = DATA_W'(pattern_data(8'(mem.mem_addr), sel_r));
   assign exp_data = (phase == PH_P1) ? cur_pat : ~cur_pat;
   assign mismatch = (state == ST_WAIT) && mem.mem_rw && mem.mem_ready && (mem.mem_rdata != exp_data);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         test_busy      <= 1'b0;
         test_done      <= 1'b0;
         test_pass      <= 1'b0;
         test_timeout   <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else begin
         test_busy <= (next_state != ST_IDLE) && (next_state != ST_DONE);
         if (load_first) begin
            test_done      <= 1'b0;
            test_pass      <= 1'b0;
            test_timeout   <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
         end else begin
            if (mismatch) begin
               if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
               if (err_count == '0) begin
                  first_err_addr <= mem.mem_addr;
                  first_err_data <= mem.mem_rdata;
               end
            end
            if (op_timeout) test_timeout <= 1'b1;
            if ((next_state == ST_DONE) && (state != ST_DONE)) begin
               test_done <= 1'b1;
               test_pass <= (err_count == '0) && !op_timeout;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_march_tester.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sram_march_tester : march BIST bench with faultable SRAM/controller model
// Revision 1.0
// ------------------------------------------------------------------
module tb_sram_march_tester;
   import sram_test_pkg::*;

   localparam int AW = 21;
   localparam int DW = 8;
   localparam int TO = DEFAULT_TIMEOUT;

   typedef struct packed {
      logic          rw;
      logic [AW-1:0] addr;
      logic [7:0]    wd;
   } op_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   logic          start, busy, done, pass, tmo;
   logic [1:0]    sel;
   logic [AW-1:0] last, fea;
   logic [15:0]   errc;
   logic [DW-1:0] fed;

   logic          start_s, busy_s, done_s, pass_s, tmo_s;
   logic [1:0]    sel_s;
   logic [AW-1:0] last_s, fea_s;
   logic [1:0]    errc_s;
   logic [DW-1:0] fed_s;

   sram_march_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   sram_march_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();

   sram_march_tester #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .test_start(start), .pattern_sel(sel), .last_addr(last),
      .mem(bus), .test_busy(busy), .test_done(done), .test_pass(pass), .test_timeout(tmo),
      .err_count(errc), .first_err_addr(fea), .first_err_data(fed)
   );

   sram_march_tester #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(2), .TIMEOUT(TO)) dut_sat (
      .clk(clk), .reset_n(reset_n), .test_start(start_s), .pattern_sel(sel_s), .last_addr(last_s),
      .mem(bus_s), .test_busy(busy_s), .test_done(done_s), .test_pass(pass_s), .test_timeout(tmo_s),
      .err_count(errc_s), .first_err_addr(fea_s), .first_err_data(fed_s)
   );

   // fault: 0 none, 1 bit3 stuck-at-0 at addr 5, 2 addr[2] tied low, 3 controller never responds
   int fault = 0;

   function automatic int phys(input int a);
      return (fault == 2) ? ((a & ~4) & 255) : (a & 255);
   endfunction

   function automatic logic [7:0] rd_fault(input int p, input logic [7:0] v);
      return (fault == 1 && p == 5) ? (v & 8'hF7) : v;
   endfunction

   function automatic logic [7:0] pat(input int s, input int a);
      case (s)
         0:       return 8'h00;
         1:       return 8'h55;
         2:       return a[7:0];
         default: return 8'hFF;
      endcase
   endfunction

   logic [7:0] sram   [256];
   logic [7:0] sram_s [256];
   logic       ctl_busy = 1'b0, ctl_ready = 1'b0;
   logic [7:0] ctl_rdata = 8'h00;
   logic       cs_busy = 1'b0, cs_ready = 1'b0;
   logic [7:0] cs_rdata = 8'h00;

   assign bus.mem_busy    = ctl_busy;
   assign bus.mem_ready   = ctl_ready;
   assign bus.mem_rdata   = ctl_rdata;
   assign bus_s.mem_busy  = cs_busy;
   assign bus_s.mem_ready = cs_ready;
   assign bus_s.mem_rdata = cs_rdata;

   always @(posedge clk) begin
      ctl_busy  <= 1'b0;
      ctl_ready <= 1'b0;
      if (bus.mem_start && fault != 3) begin
         ctl_busy <= 1'b1;
         if (bus.mem_rw) begin
            ctl_ready <= 1'b1;
            ctl_rdata <= rd_fault(phys(int'(bus.mem_addr)), sram[phys(int'(bus.mem_addr))]);
         end else begin
            sram[phys(int'(bus.mem_addr))] <= bus.mem_wdata;
         end
      end
   end

   // Second controller: every read comes back inverted.
   always @(posedge clk) begin
      cs_busy  <= 1'b0;
      cs_ready <= 1'b0;
      if (bus_s.mem_start) begin
         cs_busy <= 1'b1;
         if (bus_s.mem_rw) begin
            cs_ready <= 1'b1;
            cs_rdata <= ~sram_s[bus_s.mem_addr[7:0]];
         end else begin
            sram_s[bus_s.mem_addr[7:0]] <= bus_s.mem_wdata;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   op_t           exp_q[$];
   int            exp_err;
   logic [AW-1:0] exp_fa;
   logic [7:0]    exp_fd;

   function automatic op_t mk(input logic rw, input int a, input logic [7:0] wd);
      op_t o;
      o.rw = rw; o.addr = AW'(a); o.wd = wd;
      return o;
   endfunction

   task automatic note_read(input int a, input logic [7:0] want, input logic [7:0] m [256]);
      logic [7:0] got;
      got = rd_fault(phys(a), m[phys(a)]);
      if (got != want) begin
         if (exp_err == 0) begin exp_fa = AW'(a); exp_fd = got; end
         exp_err++;
      end
   endtask

   // March sequence and the error tally it must produce against the faulted SRAM.
   task automatic build_model(input int s, input int lst);
      logic [7:0] m [256];
      exp_q.delete();
      exp_err = 0; exp_fa = '0; exp_fd = '0;
      for (int a = 0; a <= lst; a++) begin
         exp_q.push_back(mk(1'b0, a, pat(s, a)));
         m[phys(a)] = pat(s, a);
      end
      for (int a = 0; a <= lst; a++) begin
         exp_q.push_back(mk(1'b1, a, 8'h00));
         note_read(a, pat(s, a), m);
         exp_q.push_back(mk(1'b0, a, ~pat(s, a)));
         m[phys(a)] = ~pat(s, a);
      end
      for (int a = lst; a >= 0; a--) begin
         exp_q.push_back(mk(1'b1, a, 8'h00));
         note_read(a, ~pat(s, a), m);
      end
   endtask

   int ops_seen = 0;

   always @(negedge clk) begin
      if (reset_n && bus.mem_start) begin
         op_t o;
         ops_seen++;
         if (exp_q.size() == 0) begin
            check("op_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
         end else begin
            o = exp_q.pop_front();
            check("op_rw", 32'(bus.mem_rw), 32'(o.rw));
            check("op_addr", 32'(bus.mem_addr), 32'(o.addr));
            if (!o.rw) check("op_wdata", 32'(bus.mem_wdata), 32'(o.wd));
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_mem_start"}, 32'(bus.mem_start), 0);
      check({tag, "_mem_rw"}, 32'(bus.mem_rw), 1);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
      check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_pass"}, 32'(pass), 0);
      check({tag, "_timeout"}, 32'(tmo), 0);
      check({tag, "_err_count"}, 32'(errc), 0);
      check({tag, "_first_addr"}, 32'(fea), 0);
      check({tag, "_first_data"}, 32'(fed), 0);
   endtask

   task automatic run(input int s, input int lst, input int budget, output int lat, output int ops);
      int k, base;
      build_model(s, lst);
      base = ops_seen;
      sel = 2'(s); last = AW'(lst); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = cyc;
      check("accept_busy", 32'(busy), 1);
      check("accept_mem_start", 32'(bus.mem_start), 1);
      while (!done && (cyc - k) < budget) @(negedge clk);
      check("done_reached", 32'(done), 1);
      lat = cyc - k;
      ops = ops_seen - base;
   endtask

   initial begin
      int lat, ops, k, base;
      start = 1'b0; sel = 2'd0; last = '0;
      start_s = 1'b0; sel_s = 2'd0; last_s = '0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      reset_n = 1'b1;
      @(negedge clk);

      // Clean pass, checkerboard over 16 addresses.
      fault = 0;
      run(1, 15, 400, lat, ops);
      check("clean_model_err", 32'(exp_err), 0);
      check("clean_latency_ok", 32'(lat <= 196), 1);
      check("clean_ops", 32'(ops), 64);
      check("clean_pass", 32'(pass), 1);
      check("clean_err_count", 32'(errc), 0);
      check("clean_timeout", 32'(tmo), 0);
      check("clean_busy_low", 32'(busy), 0);

      // Bit 3 stuck low at address 5, solid 0xFF.
      fault = 1;
      run(3, 15, 400, lat, ops);
      check("stuck_model_err", 32'(exp_err), 1);
      check("stuck_err_count", 32'(errc), 32'(exp_err));
      check("stuck_first_addr", 32'(fea), 5);
      check("stuck_first_data", 32'(fed), 32'h0000_00F7);
      check("stuck_pass", 32'(pass), 0);

      // addr[2] tied low, address-as-data over 8 addresses.
      fault = 2;
      run(2, 7, 300, lat, ops);
      check("alias_err_nonzero", 32'(errc > 0), 1);
      check("alias_err_count", 32'(errc), 32'(exp_err));
      check("alias_first_addr", 32'(fea), 0);
      check("alias_first_data", 32'(fed), 32'(exp_fd));
      check("alias_pass", 32'(pass), 0);

      // Controller never raises busy.
      fault = 3;
      run(0, 15, 100, lat, ops);
      check("tmo_flag", 32'(tmo), 1);
      check("tmo_latency", 32'(lat), TO + 2);
      check("tmo_pass", 32'(pass), 0);
      check("tmo_ops", 32'(ops), 1);

      // Single address; a second start mid-run must be ignored.
      fault = 0;
      build_model(2, 0);
      base = ops_seen;
      sel = 2'd2; last = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = cyc;
      repeat (3) @(negedge clk);
      sel = 2'd3; last = AW'(5); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && (cyc - k) < 100) @(negedge clk);
      check("one_done", 32'(done), 1);
      repeat (10) @(negedge clk);
      check("one_ops", 32'(ops_seen - base), 4);
      check("one_queue_empty", 32'(exp_q.size()), 0);
      check("one_pass", 32'(pass), 1);
      check("one_busy", 32'(busy), 0);

      // Reset asserted while the run is in P1.
      build_model(1, 15);
      sel = 2'd1; last = AW'(15); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (60) @(negedge clk);
      check("mid_busy_before", 32'(busy), 1);
      #2 reset_n = 1'b0;
      #1 check_reset("midrst");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      repeat (5) @(negedge clk);
      check("mid_idle_after", 32'(busy), 0);
      check("mid_no_start", 32'(bus.mem_start), 0);

      // Two-bit error counter with every read corrupted.
      sel_s = 2'd1; last_s = AW'(3); start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      k = cyc;
      while (!done_s && (cyc - k) < 200) @(negedge clk);
      check("sat_done", 32'(done_s), 1);
      check("sat_err_count", 32'(errc_s), 3);
      check("sat_pass", 32'(pass_s), 0);
      check("sat_first_addr", 32'(fea_s), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
